// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: rPLL reset/lock sequencing with retry, stable-lock user reset
// and run-time PSDA/DUTYDA updates through a req/ack handshake.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int LOCK_STABLE   = 256,
    parameter int SETTLE_CYCLES = 32,
    parameter int MAX_RETRY     = 3
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [3:0] pll_psda,
    output logic [3:0] pll_dutyda,
    input  logic       ps_req,
    input  logic [3:0] ps_phase,
    input  logic [3:0] ps_duty,
    output logic       ps_ack,
    output logic       locked,
    output logic       rst_out,
    output logic       fail,
    output logic [1:0] retry_cnt
);
    localparam int M1 = LOCK_TIMEOUT > LOCK_STABLE ? LOCK_TIMEOUT : LOCK_STABLE;
    localparam int M2 = RST_CYCLES > SETTLE_CYCLES + 1 ? RST_CYCLES : SETTLE_CYCLES + 1;
    localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);

    typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, PS_APPLY, PS_SETTLE, FAILED} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    retry_q, retry_d;
    logic [3:0]    psda_q, psda_d, duty_q, duty_d;
    logic          armed_q, armed_d, ack_q, ack_d;
    logic          pll_reset_q, locked_q, rst_out_q, fail_q;
    logic          lock_s, in_run;

    assign lock_s     = sync_q[1];
    assign in_run     = state_d inside {RUN, PS_APPLY, PS_SETTLE};
    assign pll_reset  = pll_reset_q;
    assign pll_psda   = psda_q;
    assign pll_dutyda = duty_q;
    assign ps_ack     = ack_q;
    assign locked     = locked_q;
    assign rst_out    = rst_out_q;
    assign fail       = fail_q;
    assign retry_cnt  = retry_q;

    // cnt_q counts cycles spent in the current state; every state change reloads it with 1
    always_comb begin
        state_d = state_q;
        cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
        retry_d = retry_q;
        psda_d  = psda_q;
        duty_d  = duty_q;
        ack_d   = 1'b0;
        case (state_q)
            RESET_PLL: state_d = cnt_q == CW'(RST_CYCLES) ? WAIT_LOCK : RESET_PLL;
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT)) begin
                    state_d = retry_q == 2'(MAX_RETRY) ? FAILED : RESET_PLL;
                    retry_d = retry_q == 2'(MAX_RETRY) ? retry_q : retry_q + 2'd1;
                end
            end
            STABLE: state_d = !lock_s ? WAIT_LOCK : cnt_q == CW'(LOCK_STABLE) ? RUN : STABLE;
            RUN: state_d = !lock_s ? RESET_PLL : (ps_req && armed_q) ? PS_APPLY : RUN;
            PS_APPLY: begin
                psda_d  = ps_phase;
                duty_d  = ps_duty;
                state_d = PS_SETTLE;
            end
            PS_SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYCLES + 1)) begin
                    state_d = lock_s ? RUN : RESET_PLL;
                    ack_d   = lock_s;
                end
            end
            default: state_d = FAILED;
        endcase
        if (state_d != state_q) cnt_d = CW'(1);
        if (state_d == RUN) retry_d = 2'd0;
        armed_d = ack_d ? 1'b0 : (armed_q | ~ps_req);
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= RESET_PLL;
            sync_q      <= 2'b00;
            cnt_q       <= '0;
            retry_q     <= 2'd0;
            psda_q      <= 4'b0000;
            duty_q      <= 4'b1000;
            armed_q     <= 1'b1;
            ack_q       <= 1'b0;
            pll_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            rst_out_q   <= 1'b1;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], pll_lock};
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            psda_q      <= psda_d;
            duty_q      <= duty_d;
            armed_q     <= armed_d;
            ack_q       <= ack_d;
            pll_reset_q <= state_d inside {RESET_PLL, FAILED};
            locked_q    <= in_run;
            rst_out_q   <= !in_run;
            fail_q      <= state_d == FAILED;
        end
    end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sequences the on-chip rPLL: power-up reset pulse, lock wait with timeout and bounded retry, and lock-stability qualification.
- Generates the synchronous user-domain reset released only on a stable lock.
- Applies run-time dynamic phase (PSDA) and duty (DUTYDA) changes through a req/ack handshake, with a settle window after each change.
- Sits between board clock/reset and the PLL wrapper. All clock consumers downstream (audio, video) gate on rst_out.

Parameters:
- RST_CYCLES, 16: cycles pll_reset is held high per reset attempt.
- LOCK_TIMEOUT, 65535: cycles to wait for lock before a retry.
- LOCK_STABLE, 256: consecutive synchronized-lock cycles required before run.
- SETTLE_CYCLES, 32: cycles lock is ignored after a phase/duty update.
- MAX_RETRY, 3: reset attempts after the first before declaring failure.

Ports:
- clkin, input, 1: reference clock (27 MHz); the only clock.
- reset, input, 1: asynchronous, active-high.
- pll_lock, input, 1: PLL LOCK, asynchronous to clkin.
- pll_reset, output, 1: to PLL RESET.
- pll_psda, output, 4: to PLL PSDA.
- pll_dutyda, output, 4: to PLL DUTYDA.
- ps_req, input, 1: phase/duty update request (level).
- ps_phase, input, 4: requested PSDA value.
- ps_duty, input, 4: requested DUTYDA value.
- ps_ack, output, 1: one-cycle pulse when an update completes.
- locked, output, 1: qualified lock.
- rst_out, output, 1: active-high user reset.
- fail, output, 1: sticky lock failure.
- retry_cnt, output, 2: attempts consumed.

Behaviour:
- Reset values: pll_reset=1, pll_psda=4'b0000, pll_dutyda=4'b1000, ps_ack=0, locked=0, rst_out=1, fail=0, retry_cnt=0, state=RESET_PLL.
- Asserting reset mid-operation returns every register to these values immediately.
- pll_lock passes through a 2-FF synchronizer (reset to 0) to produce lock_s. All outputs are registered.
- Cycle 0 is the first rising edge with reset low.
- RESET_PLL: pll_reset=1 for RST_CYCLES cycles, then WAIT_LOCK. The timeout counter is cleared.
- WAIT_LOCK: pll_reset=0.
  - lock_s=1: go to STABLE with the stable counter cleared.
  - Timeout counter reaches LOCK_TIMEOUT: if retry_cnt==MAX_RETRY, go to FAIL; else retry_cnt+1 and go to RESET_PLL.
- STABLE: lock_s must be 1 for LOCK_STABLE consecutive cycles, then RUN.
  - Any lock_s=0 returns to WAIT_LOCK with the timeout counter restarted; retry_cnt is unchanged.
- RUN: locked=1, rst_out=0, retry_cnt cleared on entry.
  - With pll_lock high from reset, locked rises and rst_out falls at cycle RST_CYCLES+1+LOCK_STABLE (273 with defaults).
  - lock_s=0: locked=1→0 and rst_out=0→1 on the next edge, then RESET_PLL.
- Update handshake:
  - A request is accepted only in RUN, when ps_req=1 and the request is armed.
  - The request is armed after ps_req has been seen low for at least 1 cycle since the last ack; it is armed out of reset.
  - Requests arriving in other states stay pending; ps_req must be held until ack.
- PS_APPLY (1 cycle): latch ps_phase/ps_duty into pll_psda/pll_dutyda, then PS_SETTLE.
- PS_SETTLE: lock_s is ignored for SETTLE_CYCLES cycles. locked=1 and rst_out=0 are held.
  - At the end, if lock_s=1: ps_ack=1 for one cycle, return to RUN.
  - Otherwise: no ack, locked=0, rst_out=1, go to RESET_PLL. The request remains pending and is re-served after relock.
  - pll_psda/pll_dutyda keep their last value across PLL re-resets.
- FAIL: pll_reset=1, rst_out=1, locked=0, fail=1. Sticky until reset; all requests are ignored.
- Counters saturate rather than wrap; retry_cnt never exceeds MAX_RETRY.

Test Plan:
- pll_lock tied 1 from time 0 → pll_reset low at cycle 16; locked=1 and rst_out=0 at cycle 273; retry_cnt=0.
- pll_lock held 0 → pll_reset pulses 4 times (16 cycles each, 65535 apart); retry_cnt steps 1,2,3; fail=1 with pll_reset=1; sticky until reset.
- Lock toggles low at stable-count 200, then stays high → returns to WAIT_LOCK; locked rises only after a further 256 clean cycles.
- In RUN: ps_req=1, ps_phase=4'h5, ps_duty=4'h6, lock dropped for 10 cycles inside settle → pll_psda=5 and pll_dutyda=6 one cycle after accept; ps_ack pulses 34 cycles after accept; rst_out stays 0.
- Lock drops in RUN for 1 cycle → rst_out=1 three edges later, new 16-cycle pll_reset; a held ps_req is served only after relock.
- Assert reset during PS_SETTLE → all outputs at reset values next cycle; pll_dutyda=4'b1000.
